bist_pattern_harness: RTL



---
 rtl/bist_harness_pkg.sv | 25 ++
 rtl/bist_harness_misr.sv | 40 ++++
 rtl/bist_pattern_harness.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/bist_harness_pkg.sv
// Shared types and helpers for the BIST pattern harness: FSM states, default
// polynomials and the shift-with-parity-feedback step used by both LFSR and MISR.
package bist_harness_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH,
        ST_DONE
    } state_e;

    localparam int          MAX_W         = 64;
    localparam logic [7:0]  DEF_LFSR_POLY = 8'hB8;
    localparam logic [25:0] DEF_MISR_POLY = 26'h2000023;

    // Shift left, feed the parity of the tapped bits into bit 0, trim to w bits.
    function automatic logic [MAX_W-1:0] lfsr_next(input logic [MAX_W-1:0] st,
                                                   input logic [MAX_W-1:0] poly,
                                                   input int               w);
        logic [MAX_W-1:0] mask;
        mask = (w >= MAX_W) ? '1 : ((MAX_W'(1) << w) - MAX_W'(1));
        return {st[MAX_W-2:0], ^(st & poly)} & mask;
    endfunction

endpackage

// File: rtl/bist_harness_misr.sv
// Multiple-input signature register: folds data_i into the signature when en is
// high; clr wipes it at the start of a run.
module bist_misr
    import bist_harness_pkg::*;
#(
    parameter int           W    = 26,
    parameter logic [W-1:0] POLY = W'(DEF_MISR_POLY)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] sig_o,
    output logic [W-1:0] sig_next_o
);

    logic [W-1:0] sig_q, sig_d;

    always_comb begin
        sig_d = sig_q;
        if (clr) begin
            sig_d = '0;
        end else if (en) begin
            sig_d = W'(lfsr_next(MAX_W'(sig_q), MAX_W'(POLY), W)) ^ data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig_o      = sig_q;
    assign sig_next_o = sig_d;

endmodule

// File: rtl/bist_pattern_harness.sv
// Self-checking wrapper for combinational benchmark netlists: LFSR stimulus out,
// MISR compaction of the (optionally pipelined) response, golden compare.
module bist_pattern_harness
    import bist_harness_pkg::*;
#(
    parameter int              IN_W      = 8,
    parameter int              OUT_W     = 26,
    parameter int              CNT_W     = 16,
    parameter int              DUT_LAT   = 0,
    parameter logic [IN_W-1:0] LFSR_POLY = IN_W'(DEF_LFSR_POLY),
    parameter logic [OUT_W-1:0] MISR_POLY = OUT_W'(DEF_MISR_POLY),
    parameter logic [IN_W-1:0] LFSR_SEED = IN_W'(1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_patterns,
    input  logic [OUT_W-1:0] golden,
    output logic [IN_W-1:0]  pattern_o,
    input  logic [OUT_W-1:0] response_i,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [OUT_W-1:0] signature,
    output logic [CNT_W-1:0] applied
);

    // An all-zero LFSR would lock up, so a zero seed falls back to 1.
    localparam logic [IN_W-1:0] SEED = (LFSR_SEED == '0) ? IN_W'(1) : LFSR_SEED;

    state_e           state_q, state_d;
    logic [IN_W-1:0]  lfsr_q, lfsr_d, lfsr_step;
    logic [CNT_W-1:0] applied_q, applied_d, applied_inc;
    logic [CNT_W-1:0] capt_q, capt_d, np_q, np_d;
    logic [OUT_W-1:0] golden_q, golden_d, misr_next;
    logic             pass_q, pass_d, misr_clr, issue, capture;

    assign issue = (state_q == ST_RUN);

    // Capture lags issue by DUT_LAT cycles; a valid bit rides alongside each pattern.
    generate
        if (DUT_LAT == 0) begin : g_nolat
            assign capture = issue;
        end else begin : g_lat
            logic [DUT_LAT-1:0] vld_q, vld_d;
            always_comb begin
                vld_d = (vld_q << 1) | DUT_LAT'(issue);
            end
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_q <= '0;
                end else begin
                    vld_q <= vld_d;
                end
            end
            assign capture = vld_q[DUT_LAT-1];
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        applied_d   = applied_q;
        np_d        = np_q;
        golden_d    = golden_q;
        pass_d      = pass_q;
        misr_clr    = 1'b0;
        capt_d      = capt_q + CNT_W'(capture);
        applied_inc = applied_q + CNT_W'(1);
        lfsr_step   = IN_W'(lfsr_next(MAX_W'(lfsr_q), MAX_W'(LFSR_POLY), IN_W));
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    np_d      = num_patterns;
                    golden_d  = golden;
                    lfsr_d    = SEED;
                    applied_d = '0;
                    capt_d    = '0;
                    misr_clr  = 1'b1;
                    if (num_patterns == '0) begin
                        state_d = ST_DONE;
                        pass_d  = (golden == '0);
                    end else begin
                        state_d = ST_RUN;
                        pass_d  = 1'b0;
                    end
                end
            end
            ST_RUN: begin
                applied_d = applied_inc;
                // The last pattern stays on pattern_o; the LFSR does not step past it.
                if (applied_inc == np_q) begin
                    if (DUT_LAT == 0) begin
                        state_d = ST_DONE;
                        pass_d  = (misr_next == golden_q);
                    end else begin
                        state_d = ST_FLUSH;
                    end
                end else begin
                    lfsr_d = lfsr_step;
                end
            end
            ST_FLUSH: begin
                if (capt_d == np_q) begin
                    state_d = ST_DONE;
                    pass_d  = (misr_next == golden_q);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            lfsr_q    <= SEED;
            applied_q <= '0;
            capt_q    <= '0;
            np_q      <= '0;
            golden_q  <= '0;
            pass_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            applied_q <= applied_d;
            capt_q    <= capt_d;
            np_q      <= np_d;
            golden_q  <= golden_d;
            pass_q    <= pass_d;
        end
    end

    bist_misr #(
        .W    (OUT_W),
        .POLY (MISR_POLY)
    ) u_misr (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (misr_clr),
        .en         (capture),
        .data_i     (response_i),
        .sig_o      (signature),
        .sig_next_o (misr_next)
    );

    assign pattern_o = lfsr_q;
    assign applied   = applied_q;
    assign busy      = (state_q == ST_RUN) || (state_q == ST_FLUSH);
    assign done      = (state_q == ST_DONE);
    assign pass      = pass_q;

endmodule
